// File: rtl/step_activity_tracker.sv
// Step counter and activity statistics feeding the 4-digit display stage.
// Define FAST_SIM_EN to shorten the one-second tick to CLK_HZ/10000 cycles.
module step_activity_tracker #(
  parameter int unsigned CLK_HZ          = 100_000_000,
  parameter int unsigned MODE_SECS       = 2,
  parameter int unsigned STEPS_PER_TENTH = 205,
  parameter int unsigned ACTIVE_THRESH   = 32
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic        PULSE,
  output logic [2:0]  MODE,
  output logic [13:0] binaryDigit,
  output logic        SATURATED
);

`ifdef FAST_SIM_EN
  localparam int unsigned TickCycles = (CLK_HZ / 10000 > 0) ? CLK_HZ / 10000 : 1;
`else
  localparam int unsigned TickCycles = (CLK_HZ > 0) ? CLK_HZ : 1;
`endif

  typedef enum logic [1:0] {StSteps, StDist, StActive, StRate} mode_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [13:0] clamp(input logic [15:0] v);
    return (v > 16'd9999) ? 14'd9999 : v[13:0];
  endfunction

  logic        pulse_s1_q, pulse_s2_q, pulse_s3_q;
  logic        step, tick, mode_change;
  logic [31:0] cyc_q, cyc_d;
  logic [15:0] steps_q, steps_d;
  logic [15:0] tenth_q, tenth_d;
  logic [15:0] dist_q, dist_d;
  logic [15:0] sec_q, sec_d;
  logic [15:0] rate_q, rate_d;
  logic [15:0] active_q, active_d;
  logic [15:0] msec_q, msec_d;
  logic        sat_q, sat_d;
  logic [13:0] digit_q, digit_d;
  mode_e       state_q, state_d;

  assign step = pulse_s2_q & ~pulse_s3_q & ENABLE;
  assign tick = (cyc_q == 32'(TickCycles - 1));

  always_comb begin
    cyc_d    = tick ? 32'd0 : cyc_q + 32'd1;
    steps_d  = steps_q;
    tenth_d  = tenth_q;
    dist_d   = dist_q;
    sec_d    = sec_q;
    rate_d   = rate_q;
    active_d = active_q;
    msec_d   = msec_q;
    sat_d    = sat_q;
    state_d  = state_q;

    if (step) begin
      steps_d = sat_inc(steps_q);
      if (steps_q == 16'd9999) sat_d = 1'b1;
      if (tenth_q == 16'(STEPS_PER_TENTH - 1)) begin
        tenth_d = 16'd0;
        dist_d  = sat_inc(dist_q);
      end else begin
        tenth_d = tenth_q + 16'd1;
      end
    end

    if (tick) begin
      rate_d = sec_q;
      if (sec_q >= 16'(ACTIVE_THRESH)) active_d = sat_inc(active_q);
      // A step on the tick edge belongs to the second that is just starting.
      sec_d = step ? 16'd1 : 16'd0;
      if (msec_q == 16'(MODE_SECS - 1)) begin
        msec_d = 16'd0;
        unique case (state_q)
          StSteps:  state_d = StDist;
          StDist:   state_d = StActive;
          StActive: state_d = StRate;
          StRate:   state_d = StSteps;
        endcase
      end else begin
        msec_d = msec_q + 16'd1;
      end
    end else if (step) begin
      sec_d = sat_inc(sec_q);
    end
  end

  // Normally the display lags its source by one cycle; on a mode change it takes the
  // freshly updated value so MODE and binaryDigit switch together.
  assign mode_change = (state_d != state_q);

  always_comb begin
    digit_d = 14'd0;
    unique case (state_d)
      StSteps:  digit_d = clamp(mode_change ? steps_d  : steps_q);
      StDist:   digit_d = clamp(mode_change ? dist_d   : dist_q);
      StActive: digit_d = clamp(mode_change ? active_d : active_q);
      StRate:   digit_d = clamp(mode_change ? rate_d   : rate_q);
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pulse_s1_q <= 1'b0;
      pulse_s2_q <= 1'b0;
      pulse_s3_q <= 1'b0;
      cyc_q      <= 32'd0;
      steps_q    <= 16'd0;
      tenth_q    <= 16'd0;
      dist_q     <= 16'd0;
      sec_q      <= 16'd0;
      rate_q     <= 16'd0;
      active_q   <= 16'd0;
      msec_q     <= 16'd0;
      sat_q      <= 1'b0;
      digit_q    <= 14'd0;
      state_q    <= StSteps;
    end else begin
      pulse_s1_q <= PULSE;
      pulse_s2_q <= pulse_s1_q;
      pulse_s3_q <= pulse_s2_q;
      cyc_q      <= cyc_d;
      steps_q    <= steps_d;
      tenth_q    <= tenth_d;
      dist_q     <= dist_d;
      sec_q      <= sec_d;
      rate_q     <= rate_d;
      active_q   <= active_d;
      msec_q     <= msec_d;
      sat_q      <= sat_d;
      digit_q    <= digit_d;
      state_q    <= state_d;
    end
  end

  assign MODE        = {1'b0, state_q};
  assign binaryDigit = digit_q;
  assign SATURATED   = sat_q;

endmodule

// File: tb/tb_step_activity_tracker.sv
// Directed bench for step_activity_tracker; one-second tick shortened to 2000 cycles.
module tb_step_activity_tracker;

`ifdef FAST_SIM_EN
  localparam int unsigned ClkHz = 20_000_000;
`else
  localparam int unsigned ClkHz = 2_000;
`endif

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        ENABLE = 1'b0;
  logic        PULSE = 1'b0;
  logic [2:0]  MODE;
  logic [13:0] binaryDigit;
  logic        SATURATED;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  step_activity_tracker #(
    .CLK_HZ(ClkHz),
    .MODE_SECS(2),
    .STEPS_PER_TENTH(205),
    .ACTIVE_THRESH(32)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .ENABLE(ENABLE),
    .PULSE(PULSE),
    .MODE(MODE),
    .binaryDigit(binaryDigit),
    .SATURATED(SATURATED)
  );

  always #5 CLK = ~CLK;

  // Edges since reset release; matches the DUT's tick counter phase.
  always @(posedge CLK) cyc <= RESET ? cyc + 1 : 0;

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b0;
    PULSE = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic step_pulse();
    @(negedge CLK);
    PULSE = 1'b1;
    @(negedge CLK);
    PULSE = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_reset();
    #2 RESET = 1'b0;
    #1;
    tests++;
    if (MODE !== 3'd0 || binaryDigit !== 14'd0 || SATURATED !== 1'b0) begin
      fails++;
      $display("FAIL reset_initial: mode=%0d digit=%0d sat=%0b, expected 0/0/0",
               MODE, binaryDigit, SATURATED);
    end
    @(negedge CLK);
    RESET = 1'b1;
    ENABLE = 1'b1;
    repeat (50) step_pulse();
    repeat (4) @(posedge CLK);
    #1;
    tests++;
    if (binaryDigit !== 14'd50) begin
      fails++;
      $display("FAIL reset_precount: got %0d expected 50", binaryDigit);
    end
    #2 RESET = 1'b0;
    #1;
    tests++;
    if (MODE !== 3'd0 || binaryDigit !== 14'd0 || SATURATED !== 1'b0) begin
      fails++;
      $display("FAIL reset_async: mode=%0d digit=%0d sat=%0b, expected 0/0/0",
               MODE, binaryDigit, SATURATED);
    end
    @(negedge CLK);
    RESET = 1'b1;
    step_pulse();
    repeat (4) @(posedge CLK);
    #1;
    tests++;
    if (binaryDigit !== 14'd1) begin
      fails++;
      $display("FAIL reset_resume: got %0d expected 1", binaryDigit);
    end
  endtask

  task automatic test_steps();
    do_reset();
    ENABLE = 1'b1;
    repeat (233) begin
      step_pulse();
      repeat (4) @(negedge CLK);
    end
    @(negedge CLK);
    PULSE = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    PULSE = 1'b0;
    tests++;
    if (MODE !== 3'd0 || binaryDigit !== 14'd234) begin
      fails++;
      $display("FAIL steps_count: mode=%0d digit=%0d, expected 0/234", MODE, binaryDigit);
    end
    ENABLE = 1'b0;
    repeat (10) step_pulse();
    repeat (6) @(posedge CLK);
    #1;
    tests++;
    if (binaryDigit !== 14'd234) begin
      fails++;
      $display("FAIL steps_disabled: got %0d expected 234", binaryDigit);
    end
    ENABLE = 1'b1;
  endtask

  task automatic test_distance();
    do_reset();
    ENABLE = 1'b1;
    repeat (410) step_pulse();
    wait_cyc(1000);
    tests++;
    if (MODE !== 3'd0 || binaryDigit !== 14'd410) begin
      fails++;
      $display("FAIL dist_steps410: mode=%0d digit=%0d, expected 0/410", MODE, binaryDigit);
    end
    wait_cyc(4002);
    tests++;
    if (MODE !== 3'd1 || binaryDigit !== 14'd2) begin
      fails++;
      $display("FAIL dist_410: mode=%0d digit=%0d, expected 1/2", MODE, binaryDigit);
    end
    do_reset();
    repeat (409) step_pulse();
    wait_cyc(4002);
    tests++;
    if (MODE !== 3'd1 || binaryDigit !== 14'd1) begin
      fails++;
      $display("FAIL dist_409: mode=%0d digit=%0d, expected 1/1", MODE, binaryDigit);
    end
  endtask

  task automatic test_activity();
    do_reset();
    ENABLE = 1'b1;
    repeat (40) step_pulse();
    wait_cyc(2100);
    repeat (10) step_pulse();
    wait_cyc(8000);
    tests++;
    if (MODE !== 3'd2 || binaryDigit !== 14'd1) begin
      fails++;
      $display("FAIL activity_active: mode=%0d digit=%0d, expected 2/1", MODE, binaryDigit);
    end
    wait_cyc(10100);
    repeat (10) step_pulse();
    // This step is counted on edge 12000, which is both a tick and a mode change.
    wait_cyc(11997);
    PULSE = 1'b1;
    wait_cyc(12000);
    PULSE = 1'b0;
    tests++;
    if (MODE !== 3'd3 || binaryDigit !== 14'd10) begin
      fails++;
      $display("FAIL activity_rate: mode=%0d digit=%0d, expected 3/10", MODE, binaryDigit);
    end
    wait_cyc(14001);
    tests++;
    if (MODE !== 3'd3 || binaryDigit !== 14'd1) begin
      fails++;
      $display("FAIL activity_tickstep: mode=%0d digit=%0d, expected 3/1", MODE, binaryDigit);
    end
  endtask

  task automatic test_mode_rotation();
    logic [2:0] exp_mode;
    do_reset();
    ENABLE = 1'b1;
    for (int b = 4000; b <= 16000; b += 4000) begin
      wait_cyc(b - 1);
      exp_mode = 3'(((b / 4000) - 1) % 4);
      tests++;
      if (MODE !== exp_mode) begin
        fails++;
        $display("FAIL rotation_before_%0d: got %0d expected %0d", b, MODE, exp_mode);
      end
      wait_cyc(b);
      exp_mode = 3'((b / 4000) % 4);
      tests++;
      if (MODE !== exp_mode) begin
        fails++;
        $display("FAIL rotation_at_%0d: got %0d expected %0d", b, MODE, exp_mode);
      end
    end
  endtask

  task automatic test_saturation();
    int n;
    do_reset();
    ENABLE = 1'b1;
    repeat (9999) step_pulse();
    repeat (4) @(posedge CLK);
    #1;
    tests++;
    if (SATURATED !== 1'b0) begin
      fails++;
      $display("FAIL sat_9999: got %0b expected 0", SATURATED);
    end
    step_pulse();
    repeat (3) @(posedge CLK);
    #1;
    tests++;
    if (SATURATED !== 1'b1) begin
      fails++;
      $display("FAIL sat_10000: got %0b expected 1", SATURATED);
    end
    repeat (5) step_pulse();
    repeat (4) @(posedge CLK);
    #1;
    n = 0;
    while (MODE !== 3'd0 && n < 20000) begin
      @(posedge CLK);
      #1;
      n++;
    end
    @(posedge CLK);
    #1;
    tests++;
    if (MODE !== 3'd0 || binaryDigit !== 14'd9999 || SATURATED !== 1'b1) begin
      fails++;
      $display("FAIL sat_display: mode=%0d digit=%0d sat=%0b, expected 0/9999/1",
               MODE, binaryDigit, SATURATED);
    end
    n = 0;
    while (MODE !== 3'd1 && n < 20000) begin
      @(posedge CLK);
      #1;
      n++;
    end
    @(posedge CLK);
    #1;
    tests++;
    if (MODE !== 3'd1 || binaryDigit !== 14'd48) begin
      fails++;
      $display("FAIL sat_distance: mode=%0d digit=%0d, expected 1/48", MODE, binaryDigit);
    end
  endtask

  initial begin
    test_reset();
    test_steps();
    test_distance();
    test_activity();
    test_mode_rotation();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule
